bridge_arbiter: RTL and testbench

Round-robin arbiter that shares one far-side bridge port between NUM_MASTERS near-side requesters. It uses the request/rw/address/wdata/rdata/ready bus: request is held until ready. The block sits between CPU/DMA/video masters and a single bridge into a peripheral or memory segment. Only one transaction is outstanding at a time, and far-side outputs are registered.

---
 rtl/bridge_pkg.sv | 19 +
 rtl/rr_select.sv | 29 ++
 rtl/bridge_arbiter.sv | 144 ++++++++++++++
 tb/tb_bridge_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and bus widths for the bridge arbiter and its helpers.
package bridge_pkg;

    localparam int unsigned BUS_ADDR_W = 28;
    localparam int unsigned BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    typedef struct packed {
        logic                  rw;
        logic [BUS_ADDR_W-1:0] address;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or above pointer, wrapping.
module rr_select #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    request,
    input  logic [IdxW-1:0] pointer,
    output logic            valid,
    output logic [IdxW-1:0] index
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;

    // Two copies back to back turn the wrap-around search into a plain shift.
    always_comb begin
        doubled = {request, request};
        rotated = N'(doubled >> pointer);
        valid   = 1'b0;
        index   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                index = IdxW'((i + 32'(pointer)) % N);
            end
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one registered far-side bridge port among NUM_MASTERS requesters.
module bridge_arbiter
    import bridge_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 0,
    localparam int unsigned GrantW     = $clog2(NUM_MASTERS)
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [NUM_MASTERS-1:0]            i_request,
    input  logic [NUM_MASTERS-1:0]            i_rw,
    input  logic [NUM_MASTERS*BUS_ADDR_W-1:0] i_address,
    input  logic [NUM_MASTERS*BUS_DATA_W-1:0] i_wdata,
    output logic [NUM_MASTERS*BUS_DATA_W-1:0] o_rdata,
    output logic [NUM_MASTERS-1:0]            o_ready,
    output logic [NUM_MASTERS-1:0]            o_error,
    output logic                              o_far_request,
    output logic                              o_far_rw,
    output logic [BUS_ADDR_W-1:0]             o_far_address,
    output logic [BUS_DATA_W-1:0]             o_far_wdata,
    input  logic [BUS_DATA_W-1:0]             i_far_rdata,
    input  logic                              i_far_ready,
    output logic [GrantW-1:0]                 o_grant,
    output logic                              o_busy
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                            state_q, state_d;
    bus_req_t                          far_q, far_d;
    logic                              far_request_q, far_request_d;
    logic [NUM_MASTERS-1:0]            ready_q, ready_d;
    logic [NUM_MASTERS-1:0]            error_q, error_d;
    logic [NUM_MASTERS*BUS_DATA_W-1:0] rdata_q, rdata_d;
    logic [GrantW-1:0]                 grant_q, grant_d;
    logic [GrantW-1:0]                 ptr_q, ptr_d;
    logic [CntW-1:0]                   cnt_q, cnt_d;

    logic              sel_valid;
    logic [GrantW-1:0] sel_index;
    logic [CntW-1:0]   cnt_inc;
    logic              timeout_hit;
    logic [GrantW-1:0] next_ptr;

    rr_select #(
        .N(NUM_MASTERS)
    ) u_rr_select (
        .request(i_request),
        .pointer(ptr_q),
        .valid  (sel_valid),
        .index  (sel_index)
    );

    // Saturating count of ACCESS cycles; the abort fires on the cycle it would reach TIMEOUT.
    assign cnt_inc     = (cnt_q == CntW'(TIMEOUT)) ? cnt_q : cnt_q + CntW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_inc) >= TIMEOUT);
    assign next_ptr    = (grant_q == GrantW'(NUM_MASTERS - 1)) ? '0 : grant_q + GrantW'(1);

    always_comb begin
        state_d       = state_q;
        far_d         = far_q;
        far_request_d = far_request_q;
        ready_d       = ready_q;
        error_d       = error_q;
        rdata_d       = rdata_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    far_d.rw      = i_rw[sel_index];
                    far_d.address = i_address[sel_index*BUS_ADDR_W +: BUS_ADDR_W];
                    far_d.wdata   = i_wdata[sel_index*BUS_DATA_W +: BUS_DATA_W];
                    far_request_d = 1'b1;
                    grant_d       = sel_index;
                    cnt_d         = '0;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                // Ready beats a coinciding timeout.
                if (i_far_ready) begin
                    rdata_d[grant_q*BUS_DATA_W +: BUS_DATA_W] = i_far_rdata;
                    ready_d[grant_q] = 1'b1;
                    far_request_d    = 1'b0;
                    state_d          = RELEASE;
                end else if (timeout_hit) begin
                    ready_d[grant_q] = 1'b1;
                    error_d[grant_q] = 1'b1;
                    far_request_d    = 1'b0;
                    state_d          = RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (!i_request[grant_q]) begin
                    ready_d = '0;
                    error_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            far_q         <= '0;
            far_request_q <= 1'b0;
            ready_q       <= '0;
            error_q       <= '0;
            rdata_q       <= '0;
            grant_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            far_q         <= far_d;
            far_request_q <= far_request_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
            rdata_q       <= rdata_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_rdata       = rdata_q;
    assign o_ready       = ready_q;
    assign o_error       = error_q;
    assign o_far_request = far_request_q;
    assign o_far_rw      = far_q.rw;
    assign o_far_address = far_q.address;
    assign o_far_wdata   = far_q.wdata;
    assign o_grant       = grant_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench: stimulus queues expected transactions, a negedge monitor checks the DUT.
module tb_bridge_arbiter;
    import bridge_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;
    localparam int unsigned GW = 2;

    logic            i_clock = 1'b0;
    logic            i_reset;
    logic [N-1:0]    i_request;
    logic [N-1:0]    i_rw;
    logic [N*28-1:0] i_address;
    logic [N*32-1:0] i_wdata;
    logic [N*32-1:0] o_rdata;
    logic [N-1:0]    o_ready;
    logic [N-1:0]    o_error;
    logic            o_far_request;
    logic            o_far_rw;
    logic [27:0]     o_far_address;
    logic [31:0]     o_far_wdata;
    logic [31:0]     i_far_rdata;
    logic            i_far_ready;
    logic [GW-1:0]   o_grant;
    logic            o_busy;

    bridge_arbiter #(
        .NUM_MASTERS(N),
        .TIMEOUT    (TO)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_request    (i_request),
        .i_rw         (i_rw),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_ready      (o_ready),
        .o_error      (o_error),
        .o_far_request(o_far_request),
        .o_far_rw     (o_far_rw),
        .o_far_address(o_far_address),
        .o_far_wdata  (o_far_wdata),
        .i_far_rdata  (i_far_rdata),
        .i_far_ready  (i_far_ready),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [27:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } resp_t;

    int    checks = 0;
    int    passes = 0;
    txn_t  txn_q [N][$];
    resp_t resp_q[$];
    int    grant_log[$];

    // Responder controls
    int          lat_cfg     = -1;
    logic        rdata_fixed = 1'b0;
    logic [31:0] rdata_cfg   = '0;
    logic        force_stall = 1'b0;
    int          stall_pct   = 0;
    logic        stall_now   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- far-side responder ----------------
    initial begin
        i_far_ready = 1'b0;
        i_far_rdata = '0;
        forever begin
            @(posedge i_clock); #1;
            i_far_ready = 1'b0;
            if (o_far_request === 1'b1 && i_reset === 1'b1) begin
                int lat;
                stall_now = force_stall || ($urandom_range(0, 99) < stall_pct);
                lat = stall_now ? 1000 : ((lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 7)));
                for (int c = 0; c < lat; c++) begin
                    @(posedge i_clock); #1;
                    if (o_far_request !== 1'b1) break;
                end
                if (o_far_request === 1'b1 && !stall_now) begin
                    i_far_rdata = rdata_fixed ? rdata_cfg : $urandom;
                    i_far_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor / reference model ----------------
    logic [31:0]  mdl_rdata [N];
    int           mdl_ptr   = 0;
    int           mdl_grant = 0;
    logic         prev_far  = 1'b0;
    logic         prev_busy = 1'b0;
    logic         prev_rst  = 1'b0;
    logic [N-1:0] prev_req  = '0;
    logic [N-1:0] prev_ready = '0;
    int           low_cnt   = 99;
    txn_t         held;

    always @(negedge i_clock) begin
        int    g;
        txn_t  t;
        resp_t r;
        if (i_reset !== 1'b1) begin
            mdl_ptr    = 0;
            mdl_grant  = 0;
            resp_q.delete();
            for (int k = 0; k < N; k++) mdl_rdata[k] = '0;
            prev_far   = 1'b0;
            prev_busy  = 1'b0;
            prev_req   = '0;
            prev_ready = '0;
            low_cnt    = 99;
            prev_rst   = 1'b0;
        end else begin
            if (o_far_request && !prev_far) begin
                check("far_gap", 64'(low_cnt >= 2), 64'd1);
                g = rr_pick(prev_req, mdl_ptr);
                check("grant_exists", 64'(g >= 0), 64'd1);
                if (g >= 0) begin
                    check("grant_index", 64'(o_grant), 64'(g));
                    mdl_grant = g;
                    mdl_ptr   = (g + 1) % N;
                    grant_log.push_back(g);
                    check("txn_pending", 64'(txn_q[g].size() > 0), 64'd1);
                    if (txn_q[g].size() > 0) begin
                        t = txn_q[g].pop_front();
                        check("far_fields", {o_far_rw, o_far_address, o_far_wdata},
                              {t.rw, t.addr, t.wdata});
                        held = t;
                    end
                    if (stall_now) begin
                        r.m = g; r.rdata = mdl_rdata[g]; r.err = 1'b1; r.due = cyc + TO;
                        resp_q.push_back(r);
                    end
                end
            end else begin
                if (prev_rst && !prev_busy && prev_req != '0)
                    check("arb_latency", 64'(o_far_request), 64'd1);
                if (o_far_request && prev_far)
                    check("far_stable", {o_far_rw, o_far_address, o_far_wdata},
                          {held.rw, held.addr, held.wdata});
            end

            if (i_far_ready && o_far_request) begin
                r.m = mdl_grant; r.rdata = i_far_rdata; r.err = 1'b0; r.due = cyc + 1;
                resp_q.push_back(r);
            end

            if (o_ready != '0 && prev_ready == '0) begin
                check("resp_expected", 64'(resp_q.size() > 0), 64'd1);
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    check("ready_vec", 64'(o_ready), 64'd1 << r.m);
                    check("error_vec", 64'(o_error), 64'(r.err) << r.m);
                    check("resp_cycle", 64'(cyc), 64'(r.due));
                    check("far_dropped", 64'(o_far_request), 64'd0);
                    if (!r.err) mdl_rdata[r.m] = r.rdata;
                    for (int k = 0; k < N; k++)
                        check($sformatf("rdata_slice%0d", k), 64'(o_rdata[k*32 +: 32]),
                              64'(mdl_rdata[k]));
                end
            end
            if ((o_error & ~o_ready) != '0) check("error_without_ready", 64'(o_error), 64'd0);

            prev_far   = o_far_request;
            low_cnt    = o_far_request ? 0 : low_cnt + 1;
            prev_busy  = o_busy;
            prev_req   = i_request;
            prev_ready = o_ready;
            prev_rst   = 1'b1;
        end
    end

    // ---------------- master stimulus ----------------
    logic act  [N];
    logic seen [N];
    logic en   [N];
    int   gap  [N];
    int   hold [N];
    int   waitc[N];
    int   gap_max  = 3;
    int   hold_min = 0;
    logic mutate_en = 1'b0;

    task automatic issue(input int m, input logic rw, input logic [27:0] a, input logic [31:0] d);
        txn_t t;
        i_rw[m] = rw;
        i_address[m*28 +: 28] = a;
        i_wdata[m*32 +: 32] = d;
        i_request[m] = 1'b1;
        t.rw = rw; t.addr = a; t.wdata = d;
        txn_q[m].push_back(t);
        act[m] = 1'b1; seen[m] = 1'b0; waitc[m] = 0;
    endtask

    task automatic drop(input int m);
        i_request[m] = 1'b0;
        act[m] = 1'b0;
        gap[m] = $urandom_range(0, gap_max);
    endtask

    task automatic step();
        @(posedge i_clock); #1;
        for (int m = 0; m < N; m++) begin
            if (act[m]) begin
                if (!seen[m]) begin
                    if (o_ready[m]) begin
                        seen[m] = 1'b1;
                        hold[m] = hold_min + $urandom_range(0, 2);
                        if (hold[m] == 0) drop(m);
                    end else begin
                        waitc[m]++;
                        if (waitc[m] > 200) begin
                            check($sformatf("ready_wait_m%0d", m), 64'(waitc[m]), 64'd200);
                            drop(m);
                        end else if (mutate_en && o_far_request && o_grant == GW'(m)) begin
                            i_rw[m] = $urandom_range(0, 1);
                            i_address[m*28 +: 28] = 28'($urandom);
                            i_wdata[m*32 +: 32] = $urandom;
                        end
                    end
                end else begin
                    check($sformatf("ready_hold_m%0d", m), 64'(o_ready[m]), 64'd1);
                    hold[m]--;
                    if (hold[m] <= 0) drop(m);
                end
            end else if (en[m]) begin
                if (gap[m] > 0) gap[m]--;
                else issue(m, 1'($urandom_range(0, 1)), 28'($urandom), $urandom);
            end
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        for (int m = 0; m < N; m++) begin
            i_request[m] = 1'b0;
            act[m] = 1'b0;
            txn_q[m].delete();
        end
        step();
        i_reset = 1'b1;
    endtask

    initial begin
        int gl0;
        i_reset = 1'b0; i_request = '0; i_rw = '0; i_address = '0; i_wdata = '0;
        for (int m = 0; m < N; m++) begin
            act[m] = 1'b0; seen[m] = 1'b0; en[m] = 1'b0;
            gap[m] = 0; hold[m] = 0; waitc[m] = 0;
        end
        repeat (3) step();
        check("rst_far_request", 64'(o_far_request), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_error", 64'(o_error), 64'd0);
        check("rst_rdata_zero", 64'(o_rdata != '0), 64'd0);
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        i_reset = 1'b1;
        step();

        // Single read from master 2
        lat_cfg = 3; rdata_fixed = 1'b1; rdata_cfg = 32'hDEADBEEF; hold_min = 2;
        issue(2, 1'b0, 28'h0001000, 32'h0);
        repeat (20) step();
        check("single_rdata", 64'(o_rdata[2*32 +: 32]), 64'hDEADBEEF);
        lat_cfg = -1; rdata_fixed = 1'b0; hold_min = 0;

        // Simultaneous writes from reset
        do_reset();
        gl0 = grant_log.size();
        for (int m = 0; m < N; m++) issue(m, 1'b1, 28'(32'h100 + m), 32'hA000_0000 + m);
        repeat (80) step();
        check("simul_count", 64'(grant_log.size() - gl0), 64'd4);
        for (int k = 0; k < 4; k++)
            if (gl0 + k < grant_log.size())
                check($sformatf("simul_order%0d", k), 64'(grant_log[gl0 + k]), 64'(k));

        // Fairness: masters 0 and 3 continuously requesting
        gl0 = grant_log.size();
        gap_max = 0; en[0] = 1'b1; en[3] = 1'b1;
        repeat (80) step();
        en[0] = 1'b0; en[3] = 1'b0;
        repeat (40) step();
        gap_max = 3;
        check("fair_count", 64'(grant_log.size() - gl0 >= 4), 64'd1);
        for (int i = gl0 + 1; i < grant_log.size(); i++)
            check("fair_alternate", 64'(grant_log[i] != grant_log[i-1]), 64'd1);

        // Near-side address change during ACCESS
        lat_cfg = 5;
        issue(1, 1'b0, 28'h10, 32'h0);
        repeat (3) step();
        check("stab_far_high", 64'(o_far_request), 64'd1);
        i_address[1*28 +: 28] = 28'h20;
        step();
        check("stab_addr", 64'(o_far_address), 64'h10);
        repeat (20) step();
        lat_cfg = -1;

        // Timeout then a normal transaction
        force_stall = 1'b1;
        issue(0, 1'b0, 28'h0555, 32'h0);
        repeat (2) step();
        force_stall = 1'b0;
        repeat (20) step();
        issue(0, 1'b1, 28'h0666, 32'h1234_5678);
        repeat (20) step();

        // Reset mid-ACCESS, then a 0-vs-2 tie
        force_stall = 1'b1;
        issue(1, 1'b0, 28'h0abc, 32'h0);
        repeat (4) step();
        check("pre_reset_far", 64'(o_far_request), 64'd1);
        do_reset();
        check("midrst_far", 64'(o_far_request), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_ready", 64'(o_ready), 64'd0);
        force_stall = 1'b0;
        gl0 = grant_log.size();
        issue(0, 1'b0, 28'h0777, 32'h0);
        issue(2, 1'b0, 28'h0888, 32'h0);
        repeat (30) step();
        check("midrst_tie_count", 64'(grant_log.size() - gl0), 64'd2);
        if (grant_log.size() > gl0) check("midrst_tie_winner", 64'(grant_log[gl0]), 64'd0);

        // Randomized traffic
        gap_max = 4; mutate_en = 1'b1; stall_pct = 6;
        for (int m = 0; m < N; m++) en[m] = 1'b1;
        repeat (1500) step();
        for (int m = 0; m < N; m++) en[m] = 1'b0;
        repeat (120) step();
        stall_pct = 0; mutate_en = 1'b0;

        check("resp_q_drained", 64'(resp_q.size()), 64'd0);
        for (int m = 0; m < N; m++) begin
            check($sformatf("txn_q_drained%0d", m), 64'(txn_q[m].size()), 64'd0);
            check($sformatf("master_idle%0d", m), 64'(act[m]), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
